if_id_latch: RTL and testbench

- Receiving end of the IF→ID instruction interface: the IF/ID pipeline register.
- Captures the (inst, pc) pair that fetch drives every cycle and presents it to decode with a valid bit.
- Supports decode stalls through a one-entry skid buffer. The skid is needed because instruction memory returns data one cycle after the PC, so one in-flight word must be caught when decode stalls.
- Inserts NOP bubbles on branch/jalr flush.

---
 rtl/if_id_latch_pkg.sv | 32 +++
 rtl/if_id_latch.sv | 84 ++++++++
 tb/tb_if_id_latch.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/if_id_latch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_latch_pkg
//  Description : Shared IF/ID definitions: datapath width, bubble encoding,
//                the IF/ID payload record and the latch state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_id_latch_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INST  = 32'h0000_0013;
  localparam logic [XLEN-1:0] BUBBLE_PC = 32'h0000_0000;

  // One IF/ID slot. The output register and the skid register share this
  // record, and the ID stage consumes the same record.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            valid;
  } if_id_t;

  // PASS: skid empty, input flows straight to the output register.
  // SKID: skid holds the word caught while decode was stalled.
  typedef enum logic [0:0] {
    PASS = 1'b0,
    SKID = 1'b1
  } latch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_id_latch.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_latch
//  Description : IF/ID pipeline register with a one-entry skid buffer. The
//                skid catches the word already in flight from instruction
//                memory when decode stalls; flush replaces everything with a
//                NOP bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_latch #(
  parameter int                       XLEN      = if_id_latch_pkg::XLEN,
  parameter logic [XLEN-1:0]          NOP_INST  = if_id_latch_pkg::NOP_INST,
  parameter logic [XLEN-1:0]          BUBBLE_PC = if_id_latch_pkg::BUBBLE_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_valid,
  output logic            fetch_hold
);

  import if_id_latch_pkg::*;

  localparam if_id_t BUBBLE = '{inst: NOP_INST, pc: BUBBLE_PC, valid: 1'b0};

  if_id_t       out_q;
  if_id_t       out_d;
  if_id_t       skid_q;
  if_id_t       skid_d;
  latch_state_e state;

  // The state is fully described by skid occupancy; no separate flop.
  assign state = skid_q.valid ? SKID : PASS;

  // Fetch must freeze whenever decode stalls or the skid still owes decode a word.
  assign fetch_hold = stall | skid_q.valid;

  assign out_inst  = out_q.inst;
  assign out_pc    = out_q.pc;
  assign out_valid = out_q.valid;

  // Next-state selection: flush beats stall beats normal flow.
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    if (flush) begin
      // Everything younger than the resolved branch is discarded, input included.
      out_d  = BUBBLE;
      skid_d = BUBBLE;
    end else if (state == SKID) begin
      // Input is ignored here: fetch was held and re-presents its word next cycle.
      if (!stall) begin
        out_d  = skid_q;
        skid_d = BUBBLE;
      end
    end else begin
      if (!stall) begin
        out_d = '{inst: in_inst, pc: in_pc, valid: in_valid};
      end else if (in_valid) begin
        // Catch the in-flight word; the output register keeps its instruction.
        skid_d = '{inst: in_inst, pc: in_pc, valid: 1'b1};
      end
    end
  end

  // Output and skid registers with synchronous reset to the bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= BUBBLE;
      skid_q <= BUBBLE;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_latch
//  Description : Directed self-checking bench for if_id_latch. Each step
//                drives one cycle of fetch/hazard inputs and compares outputs
//                against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_latch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_valid;
  logic        fetch_hold;

  int checks;
  int failures;

  if_id_latch dut (
    .clk        (clk),
    .rst        (rst),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .in_valid   (in_valid),
    .stall      (stall),
    .flush      (flush),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .out_valid  (out_valid),
    .fetch_hold (fetch_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word tied to its pc so inst/pc pairing errors show up.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hA500_0000 | pc;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: apply inputs, check the combinational fetch_hold, clock, settle.
  task automatic drive(input logic r, input logic s, input logic f, input logic v,
                       input logic [31:0] pc, input logic exp_hold, input string tag);
    rst      = r;
    stall    = s;
    flush    = f;
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst_of(pc);
    #1;
    check({tag, ".hold"}, {31'd0, fetch_hold}, {31'd0, exp_hold});
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc, input logic v);
    check({tag, ".pc"},    out_pc,               pc);
    check({tag, ".inst"},  out_inst,             v ? inst_of(pc) : NOP);
    check({tag, ".valid"}, {31'd0, out_valid},   {31'd0, v});
  endtask

  task automatic expect_valid(input string tag, input logic [31:0] pc);
    check({tag, ".pc"},    out_pc,             pc);
    check({tag, ".inst"},  out_inst,           inst_of(pc));
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // ---- reset with garbage on the fetch side ----
    rst      = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b1;
    in_pc    = 32'h0;
    in_inst  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check("rst1.inst",  out_inst,           NOP);
    check("rst1.valid", {31'd0, out_valid}, 32'd0);
    check("rst1.pc",    out_pc,             32'h0);
    in_inst = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check("rst2.inst",  out_inst,           NOP);
    check("rst2.valid", {31'd0, out_valid}, 32'd0);

    // ---- stream after release: one-cycle latency ----
    drive(0, 0, 0, 1, 32'h00, 1'b0, "s0");  expect_valid("s0", 32'h00);
    drive(0, 0, 0, 1, 32'h04, 1'b0, "s4");  expect_valid("s4", 32'h04);
    drive(0, 0, 0, 1, 32'h08, 1'b0, "s8");  expect_valid("s8", 32'h08);
    drive(0, 0, 0, 1, 32'h0C, 1'b0, "sC");  expect_valid("sC", 32'h0C);
    drive(0, 0, 0, 1, 32'h10, 1'b0, "s10"); expect_valid("s10", 32'h10);

    // ---- single stall: 0x14 goes to skid, 0x18 in flight is ignored ----
    drive(0, 1, 0, 1, 32'h14, 1'b1, "st1");  expect_valid("st1", 32'h10);
    drive(0, 0, 0, 1, 32'h18, 1'b1, "dr1");  expect_valid("dr1", 32'h14);
    drive(0, 0, 0, 1, 32'h18, 1'b0, "p18");  expect_valid("p18", 32'h18);
    drive(0, 0, 0, 1, 32'h1C, 1'b0, "p1C");  expect_valid("p1C", 32'h1C);
    drive(0, 0, 0, 1, 32'h20, 1'b0, "p20");  expect_valid("p20", 32'h20);

    // ---- long stall: skid loaded once with 0x24, output frozen 5 cycles ----
    drive(0, 1, 0, 1, 32'h24, 1'b1, "ls0");  expect_valid("ls0", 32'h20);
    for (int i = 1; i < 5; i++) begin
      drive(0, 1, 0, 1, 32'h28, 1'b1, $sformatf("ls%0d", i));
      expect_valid($sformatf("ls%0d", i), 32'h20);
    end
    drive(0, 0, 0, 1, 32'h28, 1'b1, "ldr");  expect_valid("ldr", 32'h24);
    drive(0, 0, 0, 1, 32'h28, 1'b0, "l28");  expect_valid("l28", 32'h28);

    // ---- flush while in SKID with stall still high ----
    drive(0, 1, 0, 1, 32'h2C, 1'b1, "fs0");  expect_valid("fs0", 32'h28);
    drive(0, 1, 1, 1, 32'h30, 1'b1, "fsf");  expect_out("fsf", 32'h0, 1'b0);
    // redirect bubble from fetch: invalid word passes through untouched
    drive(0, 0, 0, 0, 32'h34, 1'b0, "fiv");
    check("fiv.pc",    out_pc,             32'h34);
    check("fiv.inst",  out_inst,           inst_of(32'h34));
    check("fiv.valid", {31'd0, out_valid}, 32'd0);
    drive(0, 0, 0, 1, 32'h100, 1'b0, "f100"); expect_valid("f100", 32'h100);
    drive(0, 0, 0, 1, 32'h104, 1'b0, "f104"); expect_valid("f104", 32'h104);

    // ---- stall with no valid input: nothing enters the skid ----
    drive(0, 1, 0, 0, 32'h108, 1'b1, "nv0"); expect_valid("nv0", 32'h104);
    drive(0, 0, 0, 1, 32'h108, 1'b0, "nv1"); expect_valid("nv1", 32'h108);

    // ---- reset while the skid is full ----
    drive(0, 1, 0, 1, 32'h10C, 1'b1, "rs0"); expect_valid("rs0", 32'h108);
    drive(1, 1, 0, 1, 32'h110, 1'b1, "rs1"); expect_out("rs1", 32'h0, 1'b0);
    drive(0, 0, 0, 0, 32'h0,   1'b0, "rs2");
    check("rs2.valid", {31'd0, out_valid}, 32'd0);
    drive(0, 0, 0, 1, 32'h200, 1'b0, "rs3"); expect_valid("rs3", 32'h200);

    // ---- flush in PASS without stall ----
    drive(0, 0, 1, 1, 32'h204, 1'b0, "fp0"); expect_out("fp0", 32'h0, 1'b0);
    drive(0, 0, 0, 1, 32'h300, 1'b0, "fp1"); expect_valid("fp1", 32'h300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
